// File: rtl/bcd_digit_overlay.sv
// Two-stage overlay that draws NUM_FIELDS two-digit BCD fields as 4x-scaled 8x16 glyphs.
// Define OVERLAY_BLINK_EN to blink the field selected by edit_sel on a 64-frame cycle.
module bcd_digit_overlay #(
  parameter int          NUM_FIELDS  = 3,
  parameter int          X0          = 192,
  parameter int          Y0          = 320,
  parameter int          FIELD_PITCH = 128,
  parameter logic [11:0] FG_RGB      = 12'hFFF,
  parameter logic [11:0] BG_RGB      = 12'h000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    video_on,
  input  logic [9:0]              pix_x,
  input  logic [9:0]              pix_y,
  input  logic                    en,
  input  logic [8*NUM_FIELDS-1:0] bcd_in,
  input  logic [2:0]              edit_sel,
  output logic [11:0]             rgb_out,
  output logic                    in_cell
);

  // Sixteen glyph rows per digit; the top row sits in the most significant byte.
  function automatic logic [127:0] glyph_bits(input logic [3:0] digit);
    case (digit)
      4'd0:    glyph_bits = 128'h00007CC6C6CEDEF6E6C6C67C00000000;
      4'd1:    glyph_bits = 128'h00001838781818181818187E00000000;
      4'd2:    glyph_bits = 128'h00007CC6060C183060C0C6FE00000000;
      4'd3:    glyph_bits = 128'h00007CC606063C060606C67C00000000;
      4'd4:    glyph_bits = 128'h00000C1C3C6CCCFE0C0C0C1E00000000;
      4'd5:    glyph_bits = 128'h0000FEC0C0C0FC060606C67C00000000;
      4'd6:    glyph_bits = 128'h00003860C0C0FCC6C6C6C67C00000000;
      4'd7:    glyph_bits = 128'h0000FEC606060C183030303000000000;
      4'd8:    glyph_bits = 128'h00007CC6C6C67CC6C6C6C67C00000000;
      4'd9:    glyph_bits = 128'h00007CC6C6C67E0606060C7800000000;
      default: glyph_bits = '0;
    endcase
  endfunction

  logic [31:0]           pix_x_ext;
  logic [31:0]           pix_y_ext;
  logic [31:0]           row_off;
  logic                  row_hit;
  logic [NUM_FIELDS-1:0] field_hit;
  logic [NUM_FIELDS-1:0] field_units;
  logic [2:0]            field_col [NUM_FIELDS];

  assign pix_x_ext = {22'd0, pix_x};
  assign pix_y_ext = {22'd0, pix_y};
  assign row_off   = pix_y_ext - 32'(Y0);
  assign row_hit   = row_off < 32'd64;

  // Unsigned offset wraps to a huge value left of the field, so one compare bounds both sides.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_FIELDS; gi++) begin : g_field
      localparam int LEFT = X0 + gi * FIELD_PITCH;
      logic [31:0] col_off;
      assign col_off         = pix_x_ext - 32'(LEFT);
      assign field_hit[gi]   = row_hit && (col_off < 32'd64);
      assign field_units[gi] = col_off[5];
      assign field_col[gi]   = col_off[4:2];
    end
  endgenerate

`ifdef OVERLAY_BLINK_EN
  logic [5:0] frame_cnt_reg;
  logic       frame_tick;

  assign frame_tick = (pix_x == 10'd0) && (pix_y == 10'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_reg <= 6'd0;
    end else if (frame_tick) begin
      frame_cnt_reg <= frame_cnt_reg + 6'd1;
    end
  end
`else
  logic unused_edit_sel;
  assign unused_edit_sel = &{1'b0, edit_sel};
`endif

  logic       hit_next;
  logic [3:0] nibble_next;
  logic [2:0] col_next;
  logic       hide_next;

  always_comb begin
    hit_next    = 1'b0;
    nibble_next = 4'd0;
    col_next    = 3'd0;
    hide_next   = 1'b0;
    for (int k = 0; k < NUM_FIELDS; k++) begin
      if (field_hit[k]) begin
        hit_next    = en;
        nibble_next = field_units[k] ? bcd_in[8*k +: 4] : bcd_in[8*k+4 +: 4];
        col_next    = field_col[k];
`ifdef OVERLAY_BLINK_EN
        hide_next   = frame_cnt_reg[5] && (edit_sel == 3'(k));
`endif
      end
    end
  end

  logic       hit_reg;
  logic       video_reg;
  logic       hide_reg;
  logic [3:0] nibble_reg;
  logic [3:0] row_reg;
  logic [2:0] col_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_reg    <= 1'b0;
      video_reg  <= 1'b0;
      hide_reg   <= 1'b0;
      nibble_reg <= 4'd0;
      row_reg    <= 4'd0;
      col_reg    <= 3'd0;
    end else begin
      hit_reg    <= hit_next;
      video_reg  <= video_on;
      hide_reg   <= hide_next;
      nibble_reg <= nibble_next;
      row_reg    <= row_off[5:2];
      col_reg    <= col_next;
    end
  end

  logic [127:0] glyph_word;
  logic [7:0]   glyph_byte;
  logic         glyph_on;

  assign glyph_word = glyph_bits(nibble_reg);
  assign glyph_byte = glyph_word[{~row_reg, 3'b000} +: 8];
  assign glyph_on   = glyph_byte[~col_reg];

  always_ff @(posedge clk) begin
    if (reset || !(video_reg && hit_reg)) begin
      rgb_out <= 12'd0;
      in_cell <= 1'b0;
    end else begin
      rgb_out <= (glyph_on && !hide_reg) ? FG_RGB : BG_RGB;
      in_cell <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bcd_digit_overlay.sv
// Randomised and directed stimulus for bcd_digit_overlay, checked against a pixel-level model.
// Pixels are presented in arbitrary order; a frame starts whenever (0,0) is presented.
module tb_bcd_digit_overlay;

  localparam int          NF    = 3;
  localparam int          X0    = 192;
  localparam int          Y0    = 320;
  localparam int          PITCH = 128;
  localparam logic [11:0] FG    = 12'hFFF;
  localparam logic [11:0] BG    = 12'h000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        video_on = 1'b0;
  logic [9:0]  pix_x = '0;
  logic [9:0]  pix_y = '0;
  logic        en = 1'b0;
  logic [23:0] bcd_in = '0;
  logic [2:0]  edit_sel = '0;
  logic [11:0] rgb_out;
  logic        in_cell;

  always #5 clk = ~clk;

  bcd_digit_overlay #(
    .NUM_FIELDS(NF), .X0(X0), .Y0(Y0), .FIELD_PITCH(PITCH), .FG_RGB(FG), .BG_RGB(BG)
  ) dut (
    .clk(clk), .reset(reset), .video_on(video_on), .pix_x(pix_x), .pix_y(pix_y),
    .en(en), .bcd_in(bcd_in), .edit_sel(edit_sel), .rgb_out(rgb_out), .in_cell(in_cell)
  );

  // Golden 8x16 digit glyphs, one byte per row, leftmost pixel in bit 7.
  logic [7:0] font_tbl [10][16] = '{
    '{8'h00,8'h00,8'h7C,8'hC6,8'hC6,8'hCE,8'hDE,8'hF6,8'hE6,8'hC6,8'hC6,8'h7C,8'h00,8'h00,8'h00,8'h00},
    '{8'h00,8'h00,8'h18,8'h38,8'h78,8'h18,8'h18,8'h18,8'h18,8'h18,8'h18,8'h7E,8'h00,8'h00,8'h00,8'h00},
    '{8'h00,8'h00,8'h7C,8'hC6,8'h06,8'h0C,8'h18,8'h30,8'h60,8'hC0,8'hC6,8'hFE,8'h00,8'h00,8'h00,8'h00},
    '{8'h00,8'h00,8'h7C,8'hC6,8'h06,8'h06,8'h3C,8'h06,8'h06,8'h06,8'hC6,8'h7C,8'h00,8'h00,8'h00,8'h00},
    '{8'h00,8'h00,8'h0C,8'h1C,8'h3C,8'h6C,8'hCC,8'hFE,8'h0C,8'h0C,8'h0C,8'h1E,8'h00,8'h00,8'h00,8'h00},
    '{8'h00,8'h00,8'hFE,8'hC0,8'hC0,8'hC0,8'hFC,8'h06,8'h06,8'h06,8'hC6,8'h7C,8'h00,8'h00,8'h00,8'h00},
    '{8'h00,8'h00,8'h38,8'h60,8'hC0,8'hC0,8'hFC,8'hC6,8'hC6,8'hC6,8'hC6,8'h7C,8'h00,8'h00,8'h00,8'h00},
    '{8'h00,8'h00,8'hFE,8'hC6,8'h06,8'h06,8'h0C,8'h18,8'h30,8'h30,8'h30,8'h30,8'h00,8'h00,8'h00,8'h00},
    '{8'h00,8'h00,8'h7C,8'hC6,8'hC6,8'hC6,8'h7C,8'hC6,8'hC6,8'hC6,8'hC6,8'h7C,8'h00,8'h00,8'h00,8'h00},
    '{8'h00,8'h00,8'h7C,8'hC6,8'hC6,8'hC6,8'h7E,8'h06,8'h06,8'h06,8'h0C,8'h78,8'h00,8'h00,8'h00,8'h00}
  };

  int          total = 0;
  int          bad = 0;
  int          frames = 0;
  logic [12:0] exp_q [$];
  int          pos_q [$];

  task automatic check(input string tag, input logic [12:0] got, input logic [12:0] want);
    total++;
    if (got !== want) begin
      bad++;
      if (bad <= 40)
        $display("FAIL %s got in_cell/rgb=%h expected=%h", tag, got, want);
    end
  endtask

  // Expected {in_cell, rgb} for one pixel, straight from the cell geometry and font.
  function automatic logic [12:0] model_pix(input int x, input int y, input bit vid, input bit e,
                                            input logic [23:0] bcd, input int sel, input int nframes);
    logic [7:0] row_byte;
    int         left, cx, digit, gr, gc;
    bit         lit, hidden;
    if (!vid || !e) return 13'd0;
    for (int k = 0; k < NF; k++) begin
      left = X0 + k * PITCH;
      if (x >= left && x < left + 64 && y >= Y0 && y < Y0 + 64) begin
        cx    = x - left;
        digit = (cx < 32) ? int'(bcd[8*k+4 +: 4]) : int'(bcd[8*k +: 4]);
        gr    = (y - Y0) / 4;
        gc    = (cx % 32) / 4;
        lit   = 1'b0;
        if (digit <= 9) begin
          row_byte = font_tbl[digit][gr];
          lit      = row_byte[7 - gc];
        end
        hidden = 1'b0;
`ifdef OVERLAY_BLINK_EN
        hidden = (sel == k) && ((nframes % 64) >= 32);
`endif
        return {1'b1, (lit && !hidden) ? FG : BG};
      end
    end
    return 13'd0;
  endfunction

  // Present one pixel for one clock; compare the output that belongs to the pixel two clocks back.
  task automatic step(input int x, input int y, input bit vid, input bit e,
                      input logic [23:0] bcd, input int sel, input bit rst, input string tag);
    int pos;
    pix_x    = 10'(x);
    pix_y    = 10'(y);
    video_on = vid;
    en       = e;
    bcd_in   = bcd;
    edit_sel = 3'(sel);
    reset    = rst;
    if (rst) begin
      foreach (exp_q[i]) exp_q[i] = 13'd0;
      exp_q.push_back(13'd0);
      frames = 0;
    end else begin
      exp_q.push_back(model_pix(x, y, vid, e, bcd, sel, frames));
      if (x == 0 && y == 0) frames++;
    end
    pos_q.push_back(x * 1024 + y);
    @(posedge clk);
    #1;
    if (exp_q.size() >= 2) begin
      pos = pos_q.pop_front();
      check($sformatf("%s(%0d,%0d)", tag, pos / 1024, pos % 1024), {in_cell, rgb_out}, exp_q.pop_front());
    end
  endtask

  initial begin
    logic [23:0] rnd_bcd;

    for (int i = 0; i < 3; i++) step(200, 340, 1, 1, 24'h123456, 0, 1, "reset");
    for (int i = 0; i < 3; i++) step(200, 340, 1, 1, 24'h123456, 0, 0, "post_reset");
    $display("phase reset done total=%0d", total);

    for (int y = Y0 - 4; y < Y0 + 68; y++)
      for (int x = X0 - 6; x < X0 + 2 * PITCH + 70; x++)
        step(x, y, 1, 1, 24'h123456, 7, 0, "digits");
    $display("phase digits done total=%0d", total);

    step(200, 340, 1, 0, 24'h123456, 7, 0, "gate_en");
    step(200, 340, 0, 1, 24'h123456, 7, 0, "gate_video");
    step(260, 340, 1, 1, 24'h123456, 7, 0, "gap");
    step(192, 320, 1, 1, 24'h123456, 7, 0, "corner");
    $display("phase gating done total=%0d", total);

    for (int y = Y0 - 2; y < Y0 + 66; y++)
      for (int x = X0 + 2 * PITCH - 8; x < X0 + 2 * PITCH + 68; x++)
        step(x, y, 1, 1, 24'hA00000, 7, 0, "blank");
    $display("phase blank done total=%0d", total);

    for (int x = 190; x <= 300; x++)
      step(x, 340, 1, 1, (x < 230) ? 24'h123456 : 24'h987654, 7, 0, "live");
    $display("phase live done total=%0d", total);

    for (int f = 0; f < 128; f++) begin
      step(0, 0, 1, 1, 24'h888888, 1, 0, "tick");
      for (int x = X0; x < X0 + 2 * PITCH + 64; x += 4)
        step(x, Y0 + 24, 1, 1, 24'h888888, 1, 0, "blink");
    end
    $display("phase blink done total=%0d", total);

    for (int i = 0; i < 15000; i++) begin
      rnd_bcd = 24'($urandom);
      if ($urandom_range(0, 199) == 0)
        step(0, 0, 1, 1, rnd_bcd, int'($urandom_range(0, 7)), 0, "rand_tick");
      else
        step(int'($urandom_range(150, 600)), int'($urandom_range(300, 400)),
             $urandom_range(0, 9) != 0, $urandom_range(0, 9) != 0, rnd_bcd,
             int'($urandom_range(0, 7)), $urandom_range(0, 999) == 0, "random");
    end
    $display("phase random done total=%0d", total);

    step(0, 500, 0, 0, 24'h0, 7, 0, "flush");
    step(0, 500, 0, 0, 24'h0, 7, 0, "flush");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_digit_overlay.md
BCD_DIGIT_OVERLAY -- requirements
Module: bcd_digit_overlay

Interface
REQ-001 Parameter NUM_FIELDS, default 3: number of two-digit BCD fields drawn on one text row, range 1..4.
REQ-002 Parameter X0, default 192: left pixel column of field 0.
REQ-003 Parameter Y0, default 320: top pixel row of the digit row.
REQ-004 Parameter FIELD_PITCH, default 128: horizontal distance in pixels between the left edges of adjacent fields; must be >= 64.
REQ-005 Parameter FG_RGB, default 12'hFFF: glyph foreground colour.
REQ-006 Parameter BG_RGB, default 12'h000: colour of non-glyph pixels inside a digit cell.
REQ-007 clk  in  1: pixel clock.
REQ-008 reset  in  1: reset, synchronous, active-high.
REQ-009 video_on  in  1: high while the pixel is in the visible area.
REQ-010 pix_x  in  10: current pixel column.
REQ-011 pix_y  in  10: current pixel row.
REQ-012 en  in  1: overlay enable.
REQ-013 bcd_in  in  8*NUM_FIELDS: field k occupies bits [8k+7:8k]; the upper nibble is the tens digit.
REQ-014 edit_sel  in  3: index of the field being edited; values >= NUM_FIELDS mean no field is selected.
REQ-015 rgb_out  out  12: overlay pixel colour, registered.
REQ-016 in_cell  out  1: registered; high when rgb_out belongs to a digit cell.

Function
REQ-017 Each digit cell shall be 32 px wide and 64 px tall: an 8x16 font glyph scaled by 4 in both directions.
REQ-018 The tens digit of field k shall occupy columns X0+k*FIELD_PITCH to +31; the units digit shall occupy the next 32 columns. Both digits shall occupy rows Y0 to Y0+63. Bounds are inclusive.
REQ-019 The glyph row shall be (pix_y-Y0)>>2, range 0..15, and the glyph column shall be ((pix_x-cell_left)>>2), range 0..7. Column 0 maps to the glyph byte MSB.
REQ-020 The internal font ROM shall hold glyphs for nibble values 0..9. Nibble values 10..15 shall render as blank cells, painted entirely BG_RGB.
REQ-021 Stage 1 (registered): cell hit, field index, digit nibble, glyph row, glyph column and video_on are captured.
REQ-022 Stage 2 (registered): ROM byte lookup, bit select and colour mux drive rgb_out and in_cell.
REQ-023 Latency from pix_x/pix_y/video_on to rgb_out shall be exactly 2 clk cycles, fixed, with no gaps.
REQ-024 rgb_out shall be 0 and in_cell shall be 0 when the delayed video_on is low, when en was low at stage 1, or when the pixel lies outside all cells.
REQ-025 In a cell, rgb_out shall be FG_RGB where the glyph bit is 1 and BG_RGB where it is 0.
REQ-026 bcd_in and edit_sel shall be sampled at stage 1 on every pixel; a value change takes effect 2 cycles later.
REQ-027 A frame tick shall pulse for 1 cycle when pix_x==0 and pix_y==0.
REQ-028 A 6-bit frame counter shall increment on each frame tick and wrap 63->0.
REQ-029 Overlapping cells cannot occur when FIELD_PITCH >= 64. Coordinates beyond 1023 are not reachable. A cell that extends past column 639 shall be clipped only by video_on.

Reset
REQ-030 On reset, all pipeline registers, rgb_out, in_cell and the frame counter shall clear to 0 on the next clk edge.
REQ-031 Reset asserted mid-frame shall force rgb_out=0 from the cycle after assertion until 2 cycles after deassertion.
REQ-032 No output shall depend on pre-reset state after reset is released.

Configuration
REQ-033 The macro OVERLAY_BLINK_EN shall control edit-field blinking.
REQ-034 With OVERLAY_BLINK_EN defined: while frame counter bit 5 is 1, both cells of field edit_sel (when edit_sel < NUM_FIELDS) shall render BG_RGB only, with in_cell still 1. The field is visible for 32 frames and hidden for 32 frames.
REQ-035 Without OVERLAY_BLINK_EN: edit_sel shall be ignored, the frame counter shall be omitted, and all fields shall always render normally.

Verification
REQ-036 Reset: with reset=1 for 3 cycles and then released -> rgb_out=0 and in_cell=0 throughout reset and for 2 cycles after.
REQ-037 Digit render: NUM_FIELDS=3, bcd_in=24'h12_34_56, en=1, full 640x480 raster. Each of the 6 cells must match the golden bitmap scaled x4. Pixel (192,320) appears on rgb_out 2 cycles after it is presented.
REQ-038 Gating: en=0 or video_on=0 for pixel (200,340) -> rgb_out=0 and in_cell=0 two cycles later. Pixel (260,340), which lies between fields -> rgb_out=0.
REQ-039 Blank nibble: bcd_in=24'hA0_00_00 -> the tens cell of field 2 is all BG_RGB with in_cell=1.
REQ-040 Blink (macro defined): edit_sel=1 over 128 frames -> field 1 is hidden in frames 32..63 and 96..127 and visible otherwise; fields 0 and 2 are always visible. With the macro undefined, all fields are visible in every frame.
REQ-041 Live update: change bcd_in mid-line at x=230 -> pixels from x=230 onward use the new digit, with the 2-cycle lag on rgb_out.
